// File: rtl/weight_rd_agen.sv
// Weight-buffer read address generator: one BURST-beat read walk per start,
// rows advance per burst and the ping-pong bank group flips every ROWS bursts.
module weight_rd_agen #(
  parameter int unsigned ADDR_W = 15,
  parameter int unsigned LOW_W  = 8,
  parameter int unsigned NBANK  = 4,
  parameter int unsigned BURST  = 32,
  parameter int unsigned STEP   = 8,
  parameter int unsigned ROWS   = 128
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_start,
  input  logic                    i_dir,
  input  logic                    i_stall,
  output logic [NBANK-1:0]        o_bce,
  output logic [NBANK*ADDR_W-1:0] o_braddr,
  output logic                    o_busy,
  output logic                    o_done,
  output logic                    o_group
);

  localparam int unsigned ROW_W = ADDR_W - LOW_W;
  localparam int unsigned K_W   = $clog2(BURST + 1);
  localparam int unsigned HALF  = NBANK / 2;

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  state_t                  r_state;
  logic [ROW_W-1:0]        r_row;
  logic [K_W-1:0]          r_k;
  logic                    r_dir;
  logic                    r_group;
  logic                    r_busy;
  logic                    r_done;
  logic [NBANK-1:0]        r_bce;
  logic [NBANK*ADDR_W-1:0] r_braddr;

  logic                    w_idle;
  logic                    w_burst_end;
  logic                    w_issue;
  logic                    w_issue_dir;
  logic [K_W-1:0]          w_issue_k;
  logic [K_W-1:0]          w_kidx;
  logic [LOW_W-1:0]        w_low;
  logic [ADDR_W-1:0]       w_addr;
  logic [NBANK-1:0]        w_act;

  // r_k counts beats already issued; r_k==BURST means the walk is complete.
  assign w_idle      = (r_state == ST_IDLE);
  assign w_burst_end = (r_k == K_W'(BURST));
  assign w_issue     = w_idle ? i_start : (!i_stall && !w_burst_end);
  assign w_issue_dir = w_idle ? i_dir : r_dir;
  assign w_issue_k   = w_idle ? '0 : r_k;
  assign w_kidx      = w_issue_dir ? w_issue_k : (K_W'(BURST - 1) - w_issue_k);
  assign w_low       = LOW_W'(32'(w_kidx) * STEP);
  assign w_addr      = {r_row, w_low};

  // Lanes belonging to the active ping-pong group.
  always_comb begin
    w_act = '0;
    for (int unsigned i = 0; i < NBANK; i++) begin
      w_act[i] = ((i >= HALF) == r_group);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= ST_IDLE;
      r_row    <= '0;
      r_k      <= '0;
      r_dir    <= 1'b0;
      r_group  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_bce    <= '0;
      r_braddr <= '0;
    end else begin
      r_bce <= w_issue ? w_act : '0;
      if (w_issue) begin
        r_k <= w_issue_k + K_W'(1);
        for (int unsigned i = 0; i < NBANK; i++) begin
          if (w_act[i]) r_braddr[i*ADDR_W +: ADDR_W] <= w_addr;
        end
      end
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (i_start) begin
            r_state <= ST_RUN;
            r_busy  <= 1'b1;
            r_dir   <= i_dir;
          end
        end
        ST_RUN: begin
          if (!i_stall && w_burst_end) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_k     <= '0;
            if (r_row == ROW_W'(ROWS - 1)) begin
              r_row   <= '0;
              r_group <= !r_group;
            end else begin
              r_row <= r_row + ROW_W'(1);
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_bce    = r_bce;
  assign o_braddr = r_braddr;
  assign o_busy   = r_busy;
  assign o_done   = r_done;
  assign o_group  = r_group;

endmodule

// File: tb/tb_weight_rd_agen.sv
// Bench for weight_rd_agen: scenario table, hand sequences and random traffic
// checked every cycle against an address-queue reference model.
module tb_weight_rd_agen;

  localparam int AW = 15;
  localparam int LW = 8;
  localparam int NB = 4;
  localparam int BU = 32;
  localparam int ST = 8;
  localparam int RO = 128;

  logic clk = 1'b0;
  logic rst, start, dir, stall;
  logic [NB-1:0]    o_bce;
  logic [NB*AW-1:0] o_braddr;
  logic             o_busy, o_done, o_group;

  always #5 clk = ~clk;

  weight_rd_agen #(
    .ADDR_W(AW), .LOW_W(LW), .NBANK(NB), .BURST(BU), .STEP(ST), .ROWS(RO)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_dir(dir), .i_stall(stall),
    .o_bce(o_bce), .o_braddr(o_braddr), .o_busy(o_busy), .o_done(o_done),
    .o_group(o_group)
  );

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  // Reference model: a burst is a queue of its addresses, popped per unstalled beat.
  int          m_q[$];
  bit          m_busy, m_done, m_group;
  int          m_row;
  logic [NB-1:0] m_bce;
  int          m_lane[NB];

  function automatic logic [NB-1:0] grp_mask(input bit g);
    logic [NB-1:0] m;
    for (int i = 0; i < NB; i++) m[i] = ((i >= NB / 2) == g);
    return m;
  endfunction

  function automatic int lane(input int i);
    return int'(o_braddr[i*AW +: AW]);
  endfunction

  task automatic model_issue();
    int a;
    a = m_q.pop_front();
    m_bce = grp_mask(m_group);
    for (int i = 0; i < NB; i++) if (m_bce[i]) m_lane[i] = a;
  endtask

  task automatic model_edge(input bit s, input bit d, input bit st, input bit r);
    if (r) begin
      m_q.delete();
      m_busy = 0; m_done = 0; m_group = 0; m_row = 0; m_bce = '0;
      for (int i = 0; i < NB; i++) m_lane[i] = 0;
    end else if (!m_busy) begin
      m_done = 0;
      m_bce  = '0;
      if (s) begin
        for (int k = 0; k < BU; k++)
          m_q.push_back(m_row * (1 << LW) + (d ? k : BU - 1 - k) * ST);
        m_busy = 1;
        model_issue();
      end
    end else if (st) begin
      m_bce = '0;
    end else if (m_q.size() == 0) begin
      m_busy = 0; m_done = 1; m_bce = '0;
      m_row++;
      if (m_row == RO) begin
        m_row   = 0;
        m_group = !m_group;
      end
    end else begin
      model_issue();
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got %0d want %0d", name, cycle, act, exp);
    end
  endtask

  // One clock: drive inputs, advance model at the edge, compare just after it.
  task automatic step(input bit s, input bit d, input bit st, input bit r);
    logic [NB*AW-1:0] e;
    start = s; dir = d; stall = st; rst = r;
    @(posedge clk);
    model_edge(s, d, st, r);
    #1;
    cycle++;
    for (int i = 0; i < NB; i++) e[i*AW +: AW] = AW'(m_lane[i]);
    checks++;
    if (o_bce !== m_bce || o_braddr !== e || o_busy !== m_busy ||
        o_done !== m_done || o_group !== m_group) begin
      errors++;
      $display("FAIL model cyc=%0d bce %b/%b addr %h/%h busy %b/%b done %b/%b group %b/%b",
               cycle, o_bce, m_bce, o_braddr, e, o_busy, m_busy, o_done, m_done,
               o_group, m_group);
    end
  endtask

  typedef struct {
    bit dir;
    int stall_at;
    int stall_len;
    bit midstart;
    int exp_first;
    int exp_b10;
    int exp_last;
    int exp_done;
    int exp_beats;
  } scen_t;

  scen_t tbl[5];

  task automatic run_burst(input scen_t sc, input int idx);
    int n, beats, first, last, b10, donecyc, stc;
    bit st, ms;
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    step(1, sc.dir, 0, 0);
    n = 1; beats = 0; first = -1; last = -1; b10 = -1; donecyc = -1; stc = 0;
    while (donecyc < 0 && n < 100) begin
      if (o_bce != '0) begin
        if (beats == 0)  first = lane(0);
        if (beats == 10) b10 = lane(0);
        last = lane(0);
        beats++;
      end
      if (o_done) begin
        donecyc = n;
      end else begin
        st = (beats == sc.stall_at) && (stc < sc.stall_len);
        if (st) stc++;
        ms = sc.midstart && (n == 5 || n == 20);
        step(ms, !sc.dir, st, 0);
        n++;
      end
    end
    chk($sformatf("s%0d_first", idx), first, sc.exp_first);
    chk($sformatf("s%0d_beat10", idx), b10, sc.exp_b10);
    chk($sformatf("s%0d_last", idx), last, sc.exp_last);
    chk($sformatf("s%0d_done_cyc", idx), donecyc, sc.exp_done);
    chk($sformatf("s%0d_beats", idx), beats, sc.exp_beats);
  endtask

  initial begin
    int cyc;
    start = 0; dir = 0; stall = 0; rst = 1;

    tbl[0] = '{dir: 0, stall_at: -1, stall_len: 0, midstart: 0,
               exp_first: 248, exp_b10: 168, exp_last: 0,   exp_done: 33, exp_beats: 32};
    tbl[1] = '{dir: 1, stall_at: -1, stall_len: 0, midstart: 0,
               exp_first: 0,   exp_b10: 80,  exp_last: 248, exp_done: 33, exp_beats: 32};
    tbl[2] = '{dir: 0, stall_at: 10, stall_len: 3, midstart: 0,
               exp_first: 248, exp_b10: 168, exp_last: 0,   exp_done: 36, exp_beats: 32};
    tbl[3] = '{dir: 1, stall_at: 31, stall_len: 2, midstart: 1,
               exp_first: 0,   exp_b10: 80,  exp_last: 248, exp_done: 35, exp_beats: 32};
    tbl[4] = '{dir: 0, stall_at: 32, stall_len: 1, midstart: 1,
               exp_first: 248, exp_b10: 168, exp_last: 0,   exp_done: 34, exp_beats: 32};

    // Reset state
    step(0, 0, 0, 1);
    chk("rst_bce", int'(o_bce), 0);
    chk("rst_addr_nz", int'(o_braddr != '0), 0);
    chk("rst_busy", int'(o_busy), 0);
    chk("rst_group", int'(o_group), 0);

    for (int i = 0; i < 5; i++) run_burst(tbl[i], i);

    // Back-to-back bursts across the ping-pong flip
    step(0, 0, 0, 1);
    step(1, 0, 0, 0);
    for (int b = 1; b <= 129; b++) begin
      chk("b2b_first_beat", int'(o_bce != '0), 1);
      if (b == 2) chk("burst2_first_addr", lane(0), 504);
      if (b == 129) begin
        chk("b129_bce", int'(o_bce), 12);
        chk("b129_lane2", lane(2), 248);
        chk("b129_lane0_hold", lane(0), 32512);
        chk("b129_busy", int'(o_busy), 1);
        break;
      end
      cyc = 0;
      while (!o_done && cyc < 200) begin
        step(0, 0, 0, 0);
        cyc++;
      end
      if (b == 1 || b == 127 || b == 128) chk("b2b_len", cyc, 32);
      if (b == 127) chk("grp_before_flip", int'(o_group), 0);
      if (b == 128) begin
        chk("grp_flip", int'(o_group), 1);
        chk("b128_last_addr", lane(0), 32512);
      end
      step(1, 0, 0, 0);
    end
    cyc = 0;
    while (!o_done && cyc < 200) begin
      step(0, 0, 0, 0);
      cyc++;
    end
    chk("b129_len", cyc, 32);

    // Reset mid-burst at beat 15, with start held high alongside reset
    step(0, 0, 0, 1);
    step(1, 0, 0, 0);
    for (int i = 0; i < 15; i++) step(0, 0, 0, 0);
    chk("beat15_addr", lane(0), 128);
    step(1, 0, 0, 1);
    chk("midrst_bce", int'(o_bce), 0);
    chk("midrst_addr_nz", int'(o_braddr != '0), 0);
    chk("midrst_busy", int'(o_busy), 0);
    chk("midrst_done", int'(o_done), 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1, 0);
      chk("midrst_no_done", int'(o_done), 0);
    end
    step(1, 0, 0, 0);
    chk("restart_addr", lane(0), 248);
    chk("restart_bce", int'(o_bce), 3);
    chk("restart_group", int'(o_group), 0);

    // Random traffic against the model
    step(0, 0, 0, 1);
    for (int i = 0; i < 4000; i++) begin
      step($urandom_range(0, 3) == 0, 1'($urandom), $urandom_range(0, 3) == 0,
           $urandom_range(0, 199) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/weight_rd_agen.md
# weight_rd_agen

Parametrised weight-buffer read address generator for the convolution datapath. Each `start` issues one burst of `BURST` BRAM reads to the active bank group, walking the low address field by `STEP` (descending or ascending), then advancing the row. After `ROWS` bursts it flips the ping-pong group so the loader can refill the idle group. Adds stall back-pressure, a busy/done handshake and a configurable walk direction.

## Interface
- `ADDR_W`, 15, BRAM address width
- `LOW_W`, 8, width of the in-row (low) address field; the row field is `ADDR_W-LOW_W` bits
- `NBANK`, 4, total banks, even; group 0 = banks 0..NBANK/2-1, group 1 = the rest
- `BURST`, 32, reads per burst; `BURST*STEP` <= 2^LOW_W
- `STEP`, 8, low-field increment per read
- `ROWS`, 128, bursts per ping-pong buffer; <= 2^(ADDR_W-LOW_W)

- `clk` in 1 — single clock, rising edge
- `rst` in 1 — synchronous, active-high reset
- `start` in 1 — request one burst; accepted only when `busy`=0
- `dir` in 1 — sampled on accepted start: 0 descending, 1 ascending
- `stall` in 1 — downstream not ready; freezes the burst
- `bce` out NBANK — per-bank read enable, registered
- `braddr` out NBANK*ADDR_W — per-bank read address, bank i at [i*ADDR_W +: ADDR_W], registered
- `busy` out 1 — burst in progress
- `done` out 1 — one-cycle pulse after the last read of a burst
- `group` out 1 — active ping-pong group

## Operation
- States: IDLE and RUN.
  - IDLE→RUN on `start` while `busy`=0.
  - RUN→IDLE after beat `BURST-1` is issued.
- Internal state:
  - `row` (ADDR_W-LOW_W bits) and beat counter `k` (0..BURST-1).
  - Burst address = {row, low}.
  - Descending: low = (BURST-1-k)*STEP. Ascending: low = k*STEP.
- Beat issue: each RUN cycle with `stall`=0 issues beat k.
  - `bce` bits of the active group = 1; the other group's bits = 0.
  - The active group's `braddr` lanes all carry the beat address.
  - k increments.
- Stall: a RUN cycle with `stall`=1 drives all `bce`=0 and leaves k unchanged. `braddr` holds its value.
- Inactive-group `braddr` lanes hold their last value.
- End of burst: `row` increments.
  - If `row` was ROWS-1, it wraps to 0 and `group` toggles.
  - The `row` update and any `group` toggle become visible in the `done` cycle.
- `start` while `busy`=1 is ignored; there is no queueing.
- `dir` is latched at accept and stays fixed for the whole burst.
- Reset values:
  - `bce`=0, every `braddr`=0, `busy`=0, `done`=0, `group`=0.
  - `row`=0, k=0, state IDLE.
- Reset mid-burst aborts the burst. Reset values appear at the next edge, and no `done` is generated.

## Timing
- Accept: `start` sampled high at edge E0 while idle → `busy`=1 and beat 0 on `bce`/`braddr` in the cycle after E0.
- Without stalls, beat k is presented in cycle E0+1+k.
- The last beat is in cycle E0+BURST.
- In cycle E0+BURST+1: `busy`=0, `done`=1, `bce`=0.
- A `start` sampled in the `done` cycle is accepted. Back-to-back bursts therefore have exactly one idle cycle between them.
- Each stalled cycle delays every remaining beat and `done` by one cycle.
- A `stall` arriving in the `done` cycle or in IDLE has no effect.
- `start` and `rst` high together: reset wins.

## Test plan
- Reset, then one descending burst with defaults:
  - Beats in cycles 1..32 drive `bce`=4'b0011.
  - `braddr` lanes 0/1 run 248, 240, …, 0.
  - `done` rises in cycle 33.
  - Second burst addresses run 256+248 down to 256.
- Ascending burst (`dir`=1) on row 0: addresses 0, 8, …, 248.
- Stall of 3 cycles held across beat 10:
  - `bce`=0 for 3 cycles; beat 10 then resumes with address 168.
  - `done` arrives 3 cycles late.
  - No beat is skipped or duplicated.
- 128 back-to-back bursts:
  - Burst 128 ends at address 127*256 (32512 descending).
  - `group`=1 in its `done` cycle.
  - Burst 129 drives `bce`=4'b1100 starting at address 248.
  - Lanes 0/1 still hold 32512.
- `start` pulsed mid-burst is ignored (beat count stays 32). `start` in the `done` cycle gives a first beat exactly 1 cycle later.
- `rst` asserted at beat 15:
  - Next cycle all outputs are 0 and no `done` is generated.
  - A new `start` restarts at row 0, address 248, group 0.
